// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment driver with double buffering,
// leading-zero blanking and an anode-off gap at the start of each digit slot.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [31:0] digits,
    input  logic [2:0]  dp_pos,
    input  logic        dp_en,
    input  logic        lz_en,
    input  logic        load,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   act_digits, pend_digits;
    logic [2:0]    act_dp_pos, pend_dp_pos;
    logic          act_dp_en, act_lz_en, pend_dp_en, pend_lz_en, pend_v;
    logic          slot_end, boundary, blank;
    logic [3:0]    nib;
    logic [7:0]    zero_up;
    logic [6:0]    seg_code;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0111111;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        slot_end = cnt == CW'(REFRESH_DIV - 1);
        boundary = slot_end && idx == 3'd7;
        nib      = act_digits[{idx, 2'b00} +: 4];
        // zero_up[i]: every nibble from digit i up to digit 7 is zero
        for (int i = 0; i < 8; i++) zero_up[i] = (act_digits >> (4 * i)) == 32'd0;
        blank    = act_lz_en && idx != 3'd0 && (!act_dp_en || idx > act_dp_pos) && zero_up[idx];
        seg_code = blank ? 7'h7F : decode(nib);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
            act_digits  <= '0;
            act_dp_pos  <= '0;
            act_dp_en   <= 1'b0;
            act_lz_en   <= 1'b0;
            pend_digits <= '0;
            pend_dp_pos <= '0;
            pend_dp_en  <= 1'b0;
            pend_lz_en  <= 1'b0;
            pend_v      <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            idx        <= slot_end ? idx + 3'd1 : idx;
            frame_done <= boundary;
            an         <= cnt >= CW'(BLANK_CYC) ? ~(8'd1 << idx) : 8'hFF;
            seg        <= seg_code;
            dp         <= !(act_dp_en && idx == act_dp_pos);
            // A load on the boundary cycle bypasses pending and goes straight to active
            if (boundary) begin
                act_digits <= load ? digits : pend_v ? pend_digits : act_digits;
                act_dp_pos <= load ? dp_pos : pend_v ? pend_dp_pos : act_dp_pos;
                act_dp_en  <= load ? dp_en  : pend_v ? pend_dp_en  : act_dp_en;
                act_lz_en  <= load ? lz_en  : pend_v ? pend_lz_en  : act_lz_en;
                pend_v     <= 1'b0;
            end else if (load) begin
                pend_digits <= digits;
                pend_dp_pos <= dp_pos;
                pend_dp_en  <= dp_en;
                pend_lz_en  <= lz_en;
                pend_v      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver with REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg_scan_driver;
    logic        CLK100MHZ = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] digits = '0;
    logic [2:0]  dp_pos = '0;
    logic        dp_en = 1'b0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int t = 0;

    localparam logic [63:0] AN_FRAME = 64'h7FBFDFEFF7FBFDFE;

    seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .digits(digits), .dp_pos(dp_pos),
        .dp_en(dp_en), .lz_en(lz_en), .load(load), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic step;
        @(posedge CLK100MHZ);
        #1;
        t++;
    endtask

    task automatic goto_slot(input int c, input int i);
        int n = 0;
        while (!(t % 8 == c && (t / 8) % 8 == i) && n < 200) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL goto_slot: position not reached, t=%0d required cnt=%0d idx=%0d", t, c, i);
        end
    endtask

    task automatic load_val(input logic [31:0] d, input logic [2:0] p, input logic pe, input logic le);
        digits = d; dp_pos = p; dp_en = pe; lz_en = le; load = 1'b1;
        step();
        load = 1'b0;
        digits = 32'hDEAD_BEEF; dp_pos = 3'd3; dp_en = 1'b1; lz_en = 1'b1;
    endtask

    task automatic run_frame(output logic [55:0] os, output logic [7:0] odp, output logic [63:0] oan);
        int s;
        goto_slot(0, 0);
        os = '0; odp = '0; oan = '0;
        for (int k = 0; k < 64; k++) begin
            step();
            s = (t - 1) % 64;
            if (s % 8 == 4) begin
                os[7*(s/8) +: 7] = seg;
                odp[s/8] = dp;
                oan[8*(s/8) +: 8] = an;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(); step();
        vectors += 4;
        if (an !== 8'hFF) begin miscompares++; $display("FAIL reset_an: got %h want FF", an); end
        if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg: got %h want 7F", seg); end
        if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b want 1", dp); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        reset = 1'b0;
        t = 0;
    endtask

    task automatic test_scan;
        logic [7:0] ea;
        int s;
        for (int k = 0; k < 130; k++) begin
            step();
            s = t - 1;
            ea = (s % 8 >= 2) ? ~(8'd1 << ((s / 8) % 8)) : 8'hFF;
            vectors += 4;
            if (an !== ea) begin miscompares++; $display("FAIL scan_an t=%0d: got %h want %h", t, an, ea); end
            if (seg !== 7'h40) begin miscompares++; $display("FAIL scan_seg t=%0d: got %h want 40", t, seg); end
            if (dp !== 1'b1) begin miscompares++; $display("FAIL scan_dp t=%0d: got %b want 1", t, dp); end
            if (frame_done !== (t % 64 == 0)) begin
                miscompares++;
                $display("FAIL scan_fd t=%0d: got %b want %b", t, frame_done, t % 64 == 0);
            end
        end
    endtask

    task automatic test_lz_dp;
        logic [55:0] os; logic [7:0] odp; logic [63:0] oan;
        load_val(32'h0001_0000, 3'd6, 1'b1, 1'b1);
        run_frame(os, odp, oan);
        vectors += 3;
        if (os !== {7'h7F, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}) begin
            miscompares++; $display("FAIL lz_dp_seg: got %h", os);
        end
        if (odp !== 8'hBF) begin miscompares++; $display("FAIL lz_dp_dp: got %h want BF", odp); end
        if (oan !== AN_FRAME) begin miscompares++; $display("FAIL lz_dp_an: got %h want %h", oan, AN_FRAME); end
    endtask

    task automatic test_lz_all_zero;
        logic [55:0] os; logic [7:0] odp; logic [63:0] oan;
        load_val(32'h0000_0000, 3'd0, 1'b0, 1'b1);
        run_frame(os, odp, oan);
        vectors += 2;
        if (os !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
            miscompares++; $display("FAIL lz_zero_seg: got %h", os);
        end
        if (odp !== 8'hFF) begin miscompares++; $display("FAIL lz_zero_dp: got %h want FF", odp); end
    endtask

    task automatic test_late_load;
        logic [55:0] os; logic [7:0] odp; logic [63:0] oan;
        goto_slot(3, 2);
        load_val(32'h1234_5678, 3'd0, 1'b0, 1'b0);
        goto_slot(4, 3);
        step();
        vectors++;
        if (seg !== 7'h7F) begin miscompares++; $display("FAIL late_old_frame: got %h want 7F", seg); end
        load_val(32'h8765_4321, 3'd0, 1'b0, 1'b0);
        run_frame(os, odp, oan);
        vectors += 2;
        if (os !== {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}) begin
            miscompares++; $display("FAIL late_last_wins: got %h", os);
        end
        if (odp !== 8'hFF) begin miscompares++; $display("FAIL late_dp: got %h want FF", odp); end
    endtask

    task automatic test_boundary_load;
        logic [55:0] os; logic [7:0] odp; logic [63:0] oan;
        goto_slot(7, 7);
        load_val(32'h0000_0009, 3'd0, 1'b1, 1'b0);
        vectors++;
        if (t % 64 != 0) begin miscompares++; $display("FAIL bnd_pos: got t=%0d want multiple of 64", t); end
        run_frame(os, odp, oan);
        vectors += 2;
        if (os !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}) begin
            miscompares++; $display("FAIL bnd_bypass: got %h", os);
        end
        if (odp !== 8'hFE) begin miscompares++; $display("FAIL bnd_dp: got %h want FE", odp); end
        run_frame(os, odp, oan);
        vectors++;
        if (os !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}) begin
            miscompares++; $display("FAIL bnd_pend_clear: got %h", os);
        end
    endtask

    task automatic test_hex_and_reset;
        logic [55:0] os; logic [7:0] odp; logic [63:0] oan;
        load_val(32'h00C0_A000, 3'd0, 1'b0, 1'b0);
        run_frame(os, odp, oan);
        vectors++;
        if (os !== {7'h40, 7'h40, 7'h7F, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h40}) begin
            miscompares++; $display("FAIL hex_seg: got %h", os);
        end
        load_val(32'h1111_1111, 3'd0, 1'b0, 1'b0);
        goto_slot(4, 3);
        reset = 1'b1;
        step();
        vectors += 4;
        if (an !== 8'hFF) begin miscompares++; $display("FAIL midrst_an: got %h want FF", an); end
        if (seg !== 7'h7F) begin miscompares++; $display("FAIL midrst_seg: got %h want 7F", seg); end
        if (dp !== 1'b1) begin miscompares++; $display("FAIL midrst_dp: got %b want 1", dp); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL midrst_fd: got %b want 0", frame_done); end
        reset = 1'b0;
        t = 0;
        run_frame(os, odp, oan);
        vectors += 3;
        if (os !== {8{7'h40}}) begin miscompares++; $display("FAIL midrst_pend_lost: got %h", os); end
        if (odp !== 8'hFF) begin miscompares++; $display("FAIL midrst_frame_dp: got %h want FF", odp); end
        if (oan !== AN_FRAME) begin miscompares++; $display("FAIL midrst_frame_an: got %h want %h", oan, AN_FRAME); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_dp();
        test_lz_all_zero();
        test_late_load();
        test_boundary_load();
        test_hex_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the XADC sample-to-decimal stage, which supplies up to 8 BCD nibbles, a decimal-point position and a load strobe. It scans the digits at a fixed refresh rate and double-buffers the incoming value so a display frame never shows a mix of old and new digits. It also performs leading-zero blanking and inserts a short anode-off gap between digits to suppress ghosting.

## Interface

- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit, 125 Hz per frame at 100 MHz); must be ≥ 4.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- CLK100MHZ  in  1  single system clock; everything is in this domain.
- reset  in  1  synchronous, active-high reset.
- digits  in  32  eight BCD nibbles; digits[4i+3:4i] drives display digit i (i=0 rightmost).
- dp_pos  in  3  index of the digit that shows the decimal point.
- dp_en  in  1  enable for the decimal point.
- lz_en  in  1  enable for leading-zero blanking.
- load  in  1  one-cycle strobe; captures digits, dp_pos, dp_en and lz_en.
- an  out  8  anodes, active low, one-hot-low or all ones.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal-point cathode, active low.
- frame_done  out  1  one-cycle pulse at the end of every 8-digit frame.

## Operation

- Pending register: `load` copies all inputs into pending and sets pend_v. A later load before the frame boundary overwrites pending (last load wins).
- Active register: used for display. Updated only at a frame boundary, from pending, when pend_v=1. pend_v clears in the same cycle.
- Slot counter cnt runs 0..REFRESH_DIV-1. When cnt wraps, the digit index idx advances modulo 8. The frame boundary is the cycle where cnt=REFRESH_DIV-1 and idx=7.
- Nibble decode (seg, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 0xA = dash 0111111
  - 0xB–0xF = blank 1111111
- Leading-zero blanking: digit i is blanked (seg=1111111) when all of the following hold:
  - lz_en=1 and i>0
  - i > dp_pos if dp_en=1 (otherwise i > 0)
  - every active nibble j with i ≤ j ≤ 7 equals 0
- Decimal point: dp=0 when dp_en=1 and idx==dp_pos; otherwise dp=1.
- Anodes: an=~(1<<idx) when cnt ≥ BLANK_CYC; otherwise an=8'hFF. seg and dp still present the current digit's code during the gap.

## Timing

- All outputs are registered. an, seg and dp reflect the cnt/idx/active values from the previous cycle (1-cycle latency).
- Reset, held ≥1 cycle, sets:
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0
  - cnt=0, idx=0
  - active digits=0, active dp_en=0, active lz_en=0
  - pending cleared, pend_v=0
- After reset deasserts, digit 0 is first lit at cycle BLANK_CYC+1.
- frame_done asserts during the cycle after the frame boundary, for exactly 1 cycle, every 8·REFRESH_DIV cycles.
- Load timing:
  - load at the boundary cycle: the loaded values go straight to active (bypass) and pend_v stays 0.
  - load at any other cycle: the values become visible starting with digit 0 of the next frame.
- Worst-case load-to-display latency is 8·REFRESH_DIV+1 cycles.
- Reset mid-frame: takes effect on the next edge. Pending data is discarded and no frame_done is emitted.
- Input changes without `load` have no effect.
- cnt and idx wrap silently; there is no overflow state.

## Test plan

Bench parameters: REFRESH_DIV=8, BLANK_CYC=2.

- Reset, then release with no load → every lit slot shows seg=1000000 ("0"), dp=1. an cycles FE, FD, FB, F7, EF, DF, BF, 7F, each low for 6 of 8 cycles and FF for 2. frame_done pulses every 64 cycles.
- Load digits=32'h0001_0000, dp_en=1, dp_pos=6, lz_en=1:
  - digit 7 blank
  - digit 6 "0" with dp=0
  - digit 4 "1"
  - digits 0–3 and 5 show "0"
- Load digits=32'h0000_0000, lz_en=1, dp_en=0 → digits 1–7 blank, digit 0 shows "0".
- Load at cnt=3, idx=2 → the current frame keeps the old value; new digits appear from idx 0 of the next frame. A second load before the boundary replaces the first.
- Load asserted exactly on the boundary cycle → new value shown on the very next digit-0 slot. pend_v remains 0 afterwards.
- Nibbles A–F: digit 3=0xA shows 0111111, digit 5=0xC shows 1111111. Reset asserted mid-slot → the next cycle has an=FF, seg=7F, dp=1, and the pending load is lost.
